// File: rtl/seq_multi_module_if.sv
`default_nettype none
// ============================================================================
// Module : seq_multi_module_if
// Desc   : Operand/result handshake bundle for the sequential multiplier.
// Rev    : 1.0
// ============================================================================
interface seq_multi_module_if #(
   parameter int WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 is_signed;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;
   logic                 ovf;

   modport master (
      output in_valid, a, b, is_signed, out_ready,
      input  in_ready, out_valid, product, ovf
   );

   modport slave (
      input  in_valid, a, b, is_signed, out_ready,
      output in_ready, out_valid, product, ovf
   );
endinterface
`default_nettype wire

// File: rtl/seq_multi_module.sv
`default_nettype none
// ============================================================================
// Module : seq_multi_module
// Desc   : Radix-2 shift-add multiplier, signed/unsigned, valid/ready I/O.
// Rev    : 1.0
// ============================================================================
module seq_multi_module #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   seq_multi_module_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 ovf_q, ovf_d;
   logic                 sgn_q, sgn_d;
   logic                 neg_q, neg_d;

   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic [2*WIDTH-1:0]   w_sum;
   logic [2*WIDTH-1:0]   w_res;
   logic [WIDTH:0]       w_top;
   logic                 w_ovf;

   // A WIDTH-bit unsigned magnitude holds 2^(WIDTH-1), so the most-negative input is exact.
   always_comb begin
      w_mag_a = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      w_mag_b = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
      w_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
      w_res   = neg_q ? -w_sum : w_sum;
      w_top   = w_res[2*WIDTH-1:WIDTH-1];
      w_ovf   = sgn_q ? ~((&w_top) | ~(|w_top)) : (|w_res[2*WIDTH-1:WIDTH]);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      product_d = product_q;
      ovf_d     = ovf_q;
      sgn_d     = sgn_q;
      neg_d     = neg_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d  = CALC;
               cnt_d    = '0;
               mcand_d  = {{WIDTH{1'b0}}, w_mag_a};
               mplier_d = w_mag_b;
               acc_d    = '0;
               sgn_d    = bus.is_signed;
               neg_d    = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            end
         end
         CALC: begin
            acc_d    = w_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            // Last multiplier bit: publish the sign-corrected result directly.
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d   = DONE;
               cnt_d     = '0;
               product_d = w_res;
               ovf_d     = w_ovf;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         product_q <= '0;
         ovf_q     <= 1'b0;
         sgn_q     <= 1'b0;
         neg_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         ovf_q     <= ovf_d;
         sgn_q     <= sgn_d;
         neg_q     <= neg_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.product   = product_q;
   assign bus.ovf       = ovf_q;
endmodule
`default_nettype wire

// File: doc/seq_multi_module.md
SEQ_MULTI_MODULE -- requirements
Module: seq_multi_module

Interface
REQ-001 Parameter WIDTH, default 8, sets operand width in bits; legal range 2..32.
REQ-002 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port in_valid, input, 1, operand set presented.
REQ-005 Port in_ready, output, 1, block can accept operands.
REQ-006 Port a, input, WIDTH, multiplicand.
REQ-007 Port b, input, WIDTH, multiplier.
REQ-008 Port is_signed, input, 1, 1 = two's-complement operands, 0 = unsigned.
REQ-009 Port out_valid, output, 1, product available.
REQ-010 Port out_ready, input, 1, consumer takes the product.
REQ-011 Port product, output, 2*WIDTH, full-width result.
REQ-012 Port ovf, output, 1, result does not fit in WIDTH bits under the latched mode.

Function
REQ-013 FSM states are IDLE, CALC and DONE.
REQ-014 in_ready is high only in IDLE.
REQ-015 Acceptance occurs on an edge where in_valid && in_ready; a, b and is_signed are latched on that edge, and the FSM moves to CALC.
REQ-016 Inputs are ignored outside acceptance; changes to a, b or is_signed during CALC or DONE do not affect the result.
REQ-017 CALC is a radix-2 shift-add over operand magnitudes; exactly one multiplier bit is processed per cycle, with an internal counter running 0..WIDTH-1.
REQ-018 In signed mode, operand magnitudes are formed at acceptance; a magnitude of 2^(WIDTH-1) (most-negative input) is handled without loss.
REQ-019 In signed mode, the final unsigned product is two's-complement negated when the latched sign bits differ; a zero result is never negated to a non-zero value.
REQ-020 out_valid rises exactly WIDTH cycles after the acceptance edge, with the FSM in DONE; product and ovf are valid in that same cycle.
REQ-021 In DONE, product, ovf and out_valid hold stable until an edge with out_ready high; that edge returns the FSM to IDLE and deasserts out_valid.
REQ-022 out_ready is ignored outside DONE.
REQ-023 Back-to-back throughput is one result per WIDTH+2 cycles minimum, because no operand is accepted in DONE.
REQ-024 Unsigned ovf is the OR of product[2*WIDTH-1:WIDTH].
REQ-025 Signed ovf is high unless bits product[2*WIDTH-1:WIDTH-1] are all equal.
REQ-026 product[WIDTH-1:0] equals the WIDTH-bit truncated product of the earlier combinational 8-bit multiplier when WIDTH=8 and is_signed=0.
REQ-027 product and ovf hold their last values in IDLE until the next DONE; they are not cleared on handshake.

Reset
REQ-028 rst_n low immediately forces state IDLE, counter 0, product 0, ovf 0, out_valid 0, and in_ready 1, regardless of the clock.
REQ-029 Reset asserted during CALC or DONE discards the operation; no out_valid pulse follows reset release.
REQ-030 The first acceptance is possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 WIDTH=8, unsigned, a=255, b=255 -> product=0xFE01, ovf=1; out_valid exactly 8 cycles after acceptance.
REQ-032 WIDTH=8, signed, a=-3 (0xFD), b=5 -> product=0xFFF1, ovf=0.
REQ-033 WIDTH=8, signed, a=0x80, b=0x80 -> product=0x4000, ovf=1.
REQ-034 Signed, a=0x80, b=0; and unsigned, a=0, b=0xAB -> product=0x0000, ovf=0 in both cases.
REQ-035 Back-pressure: hold out_ready=0 for 5 cycles in DONE while toggling a and b with in_valid=1 -> product, ovf and out_valid stable, in_ready=0, no new acceptance; out_ready=1 -> IDLE next cycle.
REQ-036 Reset mid-CALC: pulse rst_n low at counter=3 -> all outputs reset immediately; no out_valid after release; a new operation (unsigned 12*10) yields 0x0078, ovf=0.
REQ-037 Run the above at WIDTH=4 and WIDTH=16, with a randomized signed/unsigned sweep checked against a reference model.
